// File: rtl/uart_receiver.sv
// Oversampled 8N1 UART receive engine: two-flop line synchronizer, mid-bit
// sampling FSM, registered data/status/framing-error outputs.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 BRclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_STATUS,
    output logic                 FRAME_ERR,
    output logic                 RX_BUSY
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] MID      = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST     = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [TICK_W-1:0]      tick;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   rx_p0;
    logic                   rx_s;

    // Synchronizer stage: both flops park at the idle level on reset
    always_ff @(posedge BRclk) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= UART_RX;
            rx_s  <= rx_p0;
        end
    end

    always_ff @(posedge BRclk) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            RX_DATA   <= '0;
            RX_STATUS <= 1'b0;
            FRAME_ERR <= 1'b0;
            RX_BUSY   <= 1'b0;
        end else begin
            RX_STATUS <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        tick    <= '0;
                        RX_BUSY <= 1'b1;
                    end
                end
                START: begin
                    if (tick == MID) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            tick    <= '0;
                            bit_cnt <= '0;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise
                            state   <= IDLE;
                            RX_BUSY <= 1'b0;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick == LAST) begin
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        tick    <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick == LAST) begin
                        tick <= '0;
                        if (rx_s) begin
                            RX_DATA   <= shift;
                            RX_STATUS <= 1'b1;
                            state     <= IDLE;
                            RX_BUSY   <= 1'b0;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not look like a stream of start bits
                    if (rx_s) begin
                        state   <= IDLE;
                        RX_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    RX_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: a line waveform is built up front, expected outputs
// are derived from the frame sample-time rules, then compared every cycle.
module tb_uart_receiver;

    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int MAXC = 16384;

    logic          BRclk;
    logic          reset;
    logic          UART_RX;
    logic [DB-1:0] RX_DATA;
    logic          RX_STATUS;
    logic          FRAME_ERR;
    logic          RX_BUSY;

    uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .BRclk    (BRclk),
        .reset    (reset),
        .UART_RX  (UART_RX),
        .RX_DATA  (RX_DATA),
        .RX_STATUS(RX_STATUS),
        .FRAME_ERR(FRAME_ERR),
        .RX_BUSY  (RX_BUSY)
    );

    initial begin
        BRclk = 1'b0;
        forever #5 BRclk = ~BRclk;
    end

    // Line level and reset request for each cycle, plus expected outputs
    logic          pin_a  [MAXC];
    logic          rst_a  [MAXC];
    logic [DB-1:0] e_data [MAXC];
    logic          e_st   [MAXC];
    logic          e_fe   [MAXC];
    logic          e_busy [MAXC];

    typedef struct {
        int            cyc;
        int            kind;
        logic [DB-1:0] val;
    } lit_t;
    lit_t lits[$];

    int ptr;
    int checks;
    int failures;

    task automatic put(input logic v, input int k);
        for (int i = 0; i < k; i++) begin
            pin_a[ptr] = v;
            ptr++;
        end
    endtask

    task automatic send(input logic [DB-1:0] b, input int per, input logic stop);
        put(1'b0, per);
        for (int k = 0; k < DB; k++) put(b[k], per);
        put(stop, per);
    endtask

    task automatic lit(input int cy, input int kind, input logic [DB-1:0] v);
        lit_t t;
        t.cyc  = cy;
        t.kind = kind;
        t.val  = v;
        lits.push_back(t);
    endtask

    // Synchronized line as seen by the receiver: pin delayed two edges,
    // forced to idle for two cycles after a reset edge.
    function automatic logic rxs_at(input int c);
        if (c < 2) return 1'b1;
        if (rst_a[c-1] || rst_a[c-2]) return 1'b1;
        return pin_a[c-2];
    endfunction

    // Frame rules: start seen at cycle n, start check at n+OS/2, data bit k at
    // n+OS/2+OS(k+1), stop at n+OS/2+OS(DB+1), result visible one cycle later.
    task automatic build_expect(input int nc);
        int            mode;
        int            n;
        int            d;
        logic [DB-1:0] held;
        logic [DB-1:0] acc;
        logic          r;
        logic          st;
        logic          fe;
        mode = 0; n = 0; held = '0; acc = '0;
        e_data[0] = '0; e_st[0] = 1'b0; e_fe[0] = 1'b0; e_busy[0] = 1'b0;
        for (int c = 0; c < nc - 1; c++) begin
            st = 1'b0;
            fe = 1'b0;
            r  = rxs_at(c);
            if (rst_a[c]) begin
                mode = 0;
                held = '0;
            end else if (mode == 0) begin
                if (!r) begin
                    mode = 1;
                    n    = c;
                end
            end else if (mode == 1) begin
                d = c - n - OS / 2;
                if (d == 0) begin
                    if (r) mode = 0;
                end else if (d == OS * (DB + 1)) begin
                    if (r) begin
                        held = acc;
                        st   = 1'b1;
                        mode = 0;
                    end else begin
                        fe   = 1'b1;
                        mode = 2;
                    end
                end else if (d > 0 && d % OS == 0) begin
                    acc[d / OS - 1] = r;
                end
            end else begin
                if (r) mode = 0;
            end
            e_data[c+1] = held;
            e_st[c+1]   = st;
            e_fe[c+1]   = fe;
            e_busy[c+1] = (mode != 0);
        end
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    initial begin
        int ncyc;
        int f;
        int rc;
        int r;
        int per;
        logic stop;
        logic [DB-1:0] b;

        checks   = 0;
        failures = 0;
        ptr      = 0;
        for (int i = 0; i < MAXC; i++) begin
            pin_a[i] = 1'b1;
            rst_a[i] = 1'b0;
        end

        for (int i = 0; i < 4; i++) rst_a[i] = 1'b1;
        lit(2, 2, '0);
        put(1'b1, 20);

        // Single byte: strobe 155 cycles after the pin falls
        f = ptr; send(8'h55, 16, 1'b1); lit(f + 155, 0, 8'h55);
        put(1'b1, 30);

        // Back-to-back: second strobe 160 cycles after the first
        f = ptr; send(8'hA3, 16, 1'b1); send(8'h0F, 16, 1'b1);
        lit(f + 155, 0, 8'hA3); lit(f + 315, 0, 8'h0F);
        put(1'b1, 30);

        // Glitch, then a good frame
        put(1'b0, 4); put(1'b1, 40);
        f = ptr; send(8'h81, 16, 1'b1); lit(f + 155, 0, 8'h81);
        put(1'b1, 30);

        // Framing error followed by a 40-bit break, then recovery
        f = ptr; send(8'h3C, 16, 1'b0); lit(f + 155, 1, 8'h81);
        put(1'b0, 40 * 16); lit(ptr - 1, 3, 8'h81);
        put(1'b1, 40);
        f = ptr; send(8'h3C, 16, 1'b1); lit(f + 155, 0, 8'h3C);
        put(1'b1, 30);

        // Reset in the middle of data bit 4, then a good frame
        f = ptr; send(8'hFF, 16, 1'b1);
        rc = f + 16 * 5 + 8;
        rst_a[rc] = 1'b1; lit(rc + 1, 2, '0);
        put(1'b1, 20);
        f = ptr; send(8'h12, 16, 1'b1); lit(f + 155, 0, 8'h12);
        put(1'b1, 30);

        // Baud skew: short bits, nominal, long bits
        send(8'hC6, 15, 1'b1); put(1'b1, 30);
        f = ptr; send(8'h00, 16, 1'b1); lit(f + 155, 0, 8'h00);
        put(1'b1, 30);
        f = ptr; send(8'hC6, 17, 1'b1); lit(ptr + 20, 3, 8'hC6);
        put(1'b1, 30);

        // Random traffic: gaps, glitches, long bits, bad stops, stray resets
        for (int i = 0; i < 14; i++) begin
            put(1'b1, $urandom_range(0, 30));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                put(1'b0, $urandom_range(1, 6));
                put(1'b1, 20);
            end
            per  = (r == 1) ? 17 : 16;
            stop = (r == 2) ? 1'b0 : 1'b1;
            b    = DB'($urandom);
            f    = ptr;
            send(b, per, stop);
            if (r == 3) rst_a[f + $urandom_range(0, 150)] = 1'b1;
        end
        put(1'b1, 200);
        ncyc = ptr;

        build_expect(ncyc);

        UART_RX = pin_a[0];
        reset   = rst_a[0];
        for (int c = 0; c < ncyc; c++) begin
            if (c >= 1) begin
                @(negedge BRclk);
                chk("rx_data",   c, 32'(RX_DATA),   32'(e_data[c]));
                chk("rx_status", c, 32'(RX_STATUS), 32'(e_st[c]));
                chk("frame_err", c, 32'(FRAME_ERR), 32'(e_fe[c]));
                chk("rx_busy",   c, 32'(RX_BUSY),   32'(e_busy[c]));
                foreach (lits[i]) begin
                    if (lits[i].cyc == c) begin
                        case (lits[i].kind)
                            0: begin
                                chk("lit_status", c, 32'(RX_STATUS), 32'd1);
                                chk("lit_data",   c, 32'(RX_DATA),   32'(lits[i].val));
                            end
                            1: begin
                                chk("lit_ferr",   c, 32'(FRAME_ERR), 32'd1);
                                chk("lit_held",   c, 32'(RX_DATA),   32'(lits[i].val));
                            end
                            2: begin
                                chk("lit_rst_data", c, 32'(RX_DATA), 32'd0);
                                chk("lit_rst_busy", c, 32'(RX_BUSY), 32'd0);
                                chk("lit_rst_stat", c, 32'({RX_STATUS, FRAME_ERR}), 32'd0);
                            end
                            default: begin
                                chk("lit_value",  c, 32'(RX_DATA),   32'(lits[i].val));
                            end
                        endcase
                    end
                end
            end
            @(posedge BRclk);
            #1;
            if (c + 1 < ncyc) begin
                UART_RX = pin_a[c+1];
                reset   = rst_a[c+1];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
